// File: rtl/reorder_pkg.sv
// Mode encoding and index-width helper for the reorder buffer.
package reorder_pkg;

  typedef enum logic [1:0] {MODE_SEQ, MODE_SWAP, MODE_REV, MODE_BITREV} reorder_mode_t;

  function automatic int idx_width(input int block);
    return (block > 1) ? $clog2(block) : 1;
  endfunction

endpackage

// File: rtl/reorder_addr_gen.sv
// Combinational frame-index permutation (sequential, pair-swap, reverse, bit-reverse).
// Bit-reverse order exists only with REORDER_BITREV_EN; otherwise mode 3 reads sequentially.
module reorder_addr_gen
  import reorder_pkg::*;
#(
  parameter int BLOCK = 4,
  localparam int IW = idx_width(BLOCK)
) (
  input  logic [IW-1:0] idx,
  input  logic [1:0]    mode,
  output logic [IW-1:0] perm
);

  logic [IW-1:0] rev_bits;

`ifdef REORDER_BITREV_EN
  always_comb begin
    rev_bits = '0;
    for (int b = 0; b < IW; b++) rev_bits[b] = idx[IW-1-b];
  end
`else
  assign rev_bits = idx;
`endif

  // BLOCK is 2**IW, so BLOCK-1-idx is simply the bitwise complement.
  always_comb begin
    case (reorder_mode_t'(mode))
      MODE_SWAP:   perm = idx ^ IW'(1);
      MODE_REV:    perm = ~idx;
      MODE_BITREV: perm = rev_bits;
      default:     perm = idx;
    endcase
  end

endmodule

// File: rtl/reorder_buffer.sv
// Multi-frame reorder buffer: in-order frame writes, permuted registered reads.
// Mode 3 is bit-reverse only when REORDER_BITREV_EN is defined, else sequential.
module reorder_buffer
  import reorder_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int BLOCK      = 4,
  parameter int NUM_BLOCKS = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [WIDTH-1:0]                in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [1:0]                      mode,
  output logic [WIDTH-1:0]                out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [$clog2(NUM_BLOCKS+1)-1:0] frames
);

  localparam int IW    = idx_width(BLOCK);
  localparam int FW    = idx_width(NUM_BLOCKS);
  localparam int CW    = $clog2(NUM_BLOCKS + 1);
  localparam int DEPTH = BLOCK * NUM_BLOCKS;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [IW-1:0]    wr_idx, rd_idx, rd_perm;
  logic [FW-1:0]    wr_frame, rd_frame;
  logic [1:0]       mode_q, rd_mode;
  logic             wr_en, wr_last, fetch, rd_last;

  assign in_ready = frames < CW'(NUM_BLOCKS);
  assign wr_en    = in_valid && in_ready;
  assign wr_last  = wr_en && (wr_idx == IW'(BLOCK - 1));
  assign fetch    = (frames != '0) && (!out_valid || out_ready);
  assign rd_last  = fetch && (rd_idx == IW'(BLOCK - 1));
  // The first sample of a frame uses the live mode; the rest reuse the latched copy.
  assign rd_mode  = (rd_idx == '0) ? mode : mode_q;

  reorder_addr_gen #(.BLOCK(BLOCK)) u_addr_gen (
    .idx  (rd_idx),
    .mode (rd_mode),
    .perm (rd_perm)
  );

  // BLOCK is a power of two, so frame*BLOCK+idx is a plain concatenation.
  always_ff @(posedge clk) begin
    if (wr_en) mem[{wr_frame, wr_idx}] <= in_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_idx    <= '0;
      wr_frame  <= '0;
      rd_idx    <= '0;
      rd_frame  <= '0;
      mode_q    <= '0;
      frames    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (wr_en) begin
        wr_idx <= wr_idx + 1'b1;
        if (wr_last) wr_frame <= (wr_frame == FW'(NUM_BLOCKS - 1)) ? '0 : wr_frame + 1'b1;
      end
      if (fetch) begin
        out_data  <= mem[{rd_frame, rd_perm}];
        out_valid <= 1'b1;
        rd_idx    <= rd_idx + 1'b1;
        if (rd_idx == '0) mode_q <= mode;
        if (rd_last) rd_frame <= (rd_frame == FW'(NUM_BLOCKS - 1)) ? '0 : rd_frame + 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (wr_last && !rd_last)      frames <= frames + 1'b1;
      else if (rd_last && !wr_last) frames <= frames - 1'b1;
    end
  end

endmodule
